ram_1r1w_sync_clr: RTL and testbench

RAM_1R1W_SYNC_CLR -- requirements
Module: ram_1r1w_sync_clr

---
 rtl/ram_1r1w_sync_clr.sv | 169 ++++++++++++++++
 tb/tb_ram_1r1w_sync_clr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_sync_clr.sv
// One-read/one-write synchronous RAM with per-lane write mask, a
// self-clearing init sequence after reset and an optional output register.
module ram_1r1w_sync_clr #(
  parameter int unsigned         width_p      = 8,
  parameter int unsigned         depth_p      = 512,
  parameter int unsigned         lane_width_p = 8,
  parameter bit                  wr_first_p   = 1'b0,
  parameter bit                  out_reg_p    = 1'b0,
  parameter logic [width_p-1:0]  fill_p       = '0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic                                  wr_valid_i,
  input  logic [$clog2(depth_p)-1:0]            wr_addr_i,
  input  logic [width_p-1:0]                    wr_data_i,
  input  logic [width_p/lane_width_p-1:0]       wr_mask_i,
  input  logic                                  rd_valid_i,
  input  logic [$clog2(depth_p)-1:0]            rd_addr_i,
  output logic [width_p-1:0]                    rd_data_o,
  output logic                                  rd_valid_o,
  output logic                                  ready_o
);

  localparam int unsigned lanes_lp = width_p / lane_width_p;
  localparam int unsigned aw_lp    = $clog2(depth_p);

  localparam logic [aw_lp-1:0] last_addr_lp = aw_lp'(depth_p - 1);
  localparam logic [aw_lp:0]   depth_lp     = (aw_lp + 1)'(depth_p);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [aw_lp-1:0]   cnt_q, cnt_d;

  logic [width_p-1:0] mem [depth_p];

  logic               running;
  logic               wr_in_range, rd_in_range;
  logic               wr_go, rd_go;
  logic [width_p-1:0] bit_mask;

  logic               mem_we;
  logic [aw_lp-1:0]   mem_waddr;
  logic [width_p-1:0] mem_wdata;
  logic [width_p-1:0] mem_bmask;

  logic [width_p-1:0] old_word, merged_word, rd_word;
  logic               collide;

  logic               s1_valid;
  logic [width_p-1:0] s1_data;

  assign running     = (state_q == RUN);
  assign ready_o     = running;
  assign wr_in_range = ({1'b0, wr_addr_i} < depth_lp);
  assign rd_in_range = ({1'b0, rd_addr_i} < depth_lp);
  assign wr_go       = running && wr_valid_i && wr_in_range;
  assign rd_go       = running && rd_valid_i;

  // State and clear-counter registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every address once in INIT, then stay in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == last_addr_lp) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     cnt_d = '0;
      default: state_d = INIT;
    endcase
  end

  // Expand the lane mask to a per-bit mask
  always_comb begin
    bit_mask = '0;
    for (int unsigned k = 0; k < lanes_lp; k++) begin
      bit_mask[k*lane_width_p +: lane_width_p] = {lane_width_p{wr_mask_i[k]}};
    end
  end

  // Write port mux: the clear sequence owns the port during INIT
  always_comb begin
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = fill_p;
      mem_bmask = '1;
    end else begin
      mem_we    = wr_go;
      mem_waddr = wr_addr_i;
      mem_wdata = wr_data_i;
      mem_bmask = bit_mask;
    end
  end

  // Storage array; contents are not reset, the INIT sweep defines them
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_bmask) | (mem_wdata & mem_bmask);
    end
  end

  // Read word selection, with write-first bypass on address collision
  always_comb begin
    old_word    = rd_in_range ? mem[rd_addr_i] : '0;
    merged_word = (old_word & ~bit_mask) | (wr_data_i & bit_mask);
    collide     = wr_first_p && wr_go && (wr_addr_i == rd_addr_i);
    rd_word     = collide ? merged_word : old_word;
  end

  // First read stage; data holds between reads
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (out_reg_p) begin : g_out_reg
      logic               s2_valid;
      logic [width_p-1:0] s2_data;

      // Optional output register stage; data holds between reads
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid_o = s2_valid;
      assign rd_data_o  = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid_o = s1_valid;
      assign rd_data_o  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_1r1w_sync_clr.sv
// Directed bench: two instances share stimulus, one read-old/no output
// register, one write-first/with output register.
module tb_ram_1r1w_sync_clr;

  localparam logic [15:0] FILL = 16'hA5A5;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        rd_valid;
  logic [2:0]  rd_addr;

  logic [15:0] data0, data1;
  logic        valid0, valid1;
  logic        ready0, ready1;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_mem [6];

  ram_1r1w_sync_clr #(
    .width_p      (16),
    .depth_p      (6),
    .lane_width_p (8),
    .wr_first_p   (1'b0),
    .out_reg_p    (1'b0),
    .fill_p       (FILL)
  ) dut0 (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .wr_valid_i (wr_valid),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_mask_i  (wr_mask),
    .rd_valid_i (rd_valid),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (data0),
    .rd_valid_o (valid0),
    .ready_o    (ready0)
  );

  ram_1r1w_sync_clr #(
    .width_p      (16),
    .depth_p      (6),
    .lane_width_p (8),
    .wr_first_p   (1'b1),
    .out_reg_p    (1'b1),
    .fill_p       (FILL)
  ) dut1 (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .wr_valid_i (wr_valid),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_mask_i  (wr_mask),
    .rd_valid_i (rd_valid),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (data1),
    .rd_valid_o (valid1),
    .ready_o    (ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " data0"},  {16'h0, data0},  32'h0);
    check({tag, " valid0"}, {31'h0, valid0}, 32'h0);
    check({tag, " ready0"}, {31'h0, ready0}, 32'h0);
    check({tag, " data1"},  {16'h0, data1},  32'h0);
    check({tag, " valid1"}, {31'h0, valid1}, 32'h0);
    check({tag, " ready1"}, {31'h0, ready1}, 32'h0);
  endtask

  // ready must stay low for exactly 6 sampled cycles after release, then rise
  task automatic check_init(input string tag);
    for (int i = 0; i < 6; i++) begin
      check({tag, " ready0 low"}, {31'h0, ready0}, 32'h0);
      check({tag, " ready1 low"}, {31'h0, ready1}, 32'h0);
      check({tag, " valid0 low"}, {31'h0, valid0}, 32'h0);
      check({tag, " valid1 low"}, {31'h0, valid1}, 32'h0);
      tick();
    end
    check({tag, " ready0 high"}, {31'h0, ready0}, 32'h1);
    check({tag, " ready1 high"}, {31'h0, ready1}, 32'h1);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [2:0] a,
                          input logic [15:0] e0, input logic [15:0] e1);
    rd_valid = 1'b1;
    rd_addr  = a;
    tick();
    rd_valid = 1'b0;
    check({tag, " valid0"},     {31'h0, valid0}, 32'h1);
    check({tag, " data0"},      {16'h0, data0},  {16'h0, e0});
    check({tag, " valid1 early"}, {31'h0, valid1}, 32'h0);
    tick();
    check({tag, " valid1"},     {31'h0, valid1}, 32'h1);
    check({tag, " data1"},      {16'h0, data1},  {16'h0, e1});
    check({tag, " valid0 pulse"}, {31'h0, valid0}, 32'h0);
    check({tag, " data0 hold"}, {16'h0, data0},  {16'h0, e0});
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 6; i++) begin
      read_one($sformatf("%s a%0d", tag, i), 3'(i), exp_mem[i], exp_mem[i]);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    for (int i = 0; i < 6; i++) exp_mem[i] = FILL;

    repeat (2) tick();
    check_zero_outputs("reset");

    // init sweep and fill contents
    reset_n = 1'b1;
    check_init("init");
    read_all("fill");

    // masked write: only low lane changes; zero mask changes nothing
    write_word(3'd2, 16'h1234, 2'b01);
    exp_mem[2] = 16'hA534;
    read_one("mask01", 3'd2, 16'hA534, 16'hA534);
    write_word(3'd2, 16'hFFFF, 2'b00);
    read_one("mask00", 3'd2, 16'hA534, 16'hA534);

    // collision: read-old on dut0, write-first on dut1
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; wr_mask = 2'b11;
    rd_valid = 1'b1; rd_addr = 3'd3;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("coll valid0", {31'h0, valid0}, 32'h1);
    check("coll data0",  {16'h0, data0},  32'hA5A5);
    tick();
    check("coll valid1", {31'h0, valid1}, 32'h1);
    check("coll data1",  {16'h0, data1},  32'hBEEF);
    exp_mem[3] = 16'hBEEF;
    read_one("post coll", 3'd3, 16'hBEEF, 16'hBEEF);

    // back-to-back reads of 0,1,2
    rd_valid = 1'b1; rd_addr = 3'd0;
    tick();
    check("b2b c1 valid0", {31'h0, valid0}, 32'h1);
    check("b2b c1 data0",  {16'h0, data0},  32'hA5A5);
    check("b2b c1 valid1", {31'h0, valid1}, 32'h0);
    rd_addr = 3'd1;
    tick();
    check("b2b c2 valid0", {31'h0, valid0}, 32'h1);
    check("b2b c2 data0",  {16'h0, data0},  32'hA5A5);
    check("b2b c2 valid1", {31'h0, valid1}, 32'h1);
    check("b2b c2 data1",  {16'h0, data1},  32'hA5A5);
    rd_addr = 3'd2;
    tick();
    rd_valid = 1'b0;
    check("b2b c3 valid0", {31'h0, valid0}, 32'h1);
    check("b2b c3 data0",  {16'h0, data0},  32'hA534);
    check("b2b c3 valid1", {31'h0, valid1}, 32'h1);
    check("b2b c3 data1",  {16'h0, data1},  32'hA5A5);
    tick();
    check("b2b c4 valid0", {31'h0, valid0}, 32'h0);
    check("b2b c4 data0",  {16'h0, data0},  32'hA534);
    check("b2b c4 valid1", {31'h0, valid1}, 32'h1);
    check("b2b c4 data1",  {16'h0, data1},  32'hA534);
    tick();
    check("b2b c5 valid1", {31'h0, valid1}, 32'h0);
    check("b2b c5 data1",  {16'h0, data1},  32'hA534);

    // out-of-range write dropped, out-of-range read returns zero
    write_word(3'd7, 16'h1111, 2'b11);
    read_one("oor a7", 3'd7, 16'h0000, 16'h0000);
    read_one("oor a6", 3'd6, 16'h0000, 16'h0000);
    read_all("after oor");

    // reset from RUN forces outputs low at once
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async reset");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // reset in the middle of INIT, then requests ignored during the new sweep
    reset_n = 1'b0;
    #1;
    check_zero_outputs("mid init reset");
    tick();
    reset_n  = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'h0000; wr_mask = 2'b11;
    rd_valid = 1'b1; rd_addr = 3'd1;
    check_init("reinit");
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) exp_mem[i] = FILL;
    read_all("refill");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
